pmod_traffic_monitor: RTL
=========================

Name: pmod_traffic_monitor

Overview:
Receive-side companion to the intersection controller board: samples the PMOD lamp bus driven by a remote controller (remote reset, start, two car and two walk lamp groups). Synchronises and debounces the lines, then tracks remote link/run state. Checks every lamp pattern for illegal codes and conflicting right-of-way, measures phase durations and flags a stuck controller. Sits at the top of the monitor board, beside LED/seven-segment display logic that consumes its outputs.

Parameters:
STABLE_CYCLES, 16, consecutive identical synchronised samples required before a new bus value is accepted (>=2)
TIMEOUT_CYCLES, 1000000000, RUN cycles with no accepted lamp change before stuck fault (10 s at 100 MHz)
LEN_W, 32, width of phase_len

Ports:
clk  in  1  system clock, 100 MHz
rstn  in  1  asynchronous active-low reset
rx_rstn  in  1  remote controller reset line (active-low)
rx_start  in  1  remote start line
rx_car_0  in  4  path-0 car lamps: [3] red, [2] yellow, [1] left arrow, [0] green
rx_walk_0  in  2  path-0 walk lamps: [1] red, [0] green
rx_car_1  in  4  path-1 car lamps, same encoding
rx_walk_1  in  2  path-1 walk lamps, same encoding
fault_clr  in  1  single-cycle pulse, clears a latched fault
car_0_q, car_1_q  out  4  debounced car lamps
walk_0_q, walk_1_q  out  2  debounced walk lamps
link_up  out  1  state != IDLE
running  out  1  state == RUN
change_strobe  out  1  one-cycle pulse when an accepted lamp change occurs in RUN
phase_len  out  LEN_W  clk cycles the previous lamp pattern was held; saturates at all-ones
fault  out  1  state == FAULT
fault_code  out  3  0 none, 1 illegal car code, 2 illegal walk code, 3 car/car conflict, 4 walk/car conflict, 5 stuck

Behaviour:
- Reset (rstn low, async): all registers cleared; state IDLE; all outputs 0; synchroniser and debounce registers 0.
- Input path: 14-bit vector {rx_rstn, rx_start, car_1, walk_1, car_0, walk_0} passes two flops per bit. The debounce counter restarts whenever the synchronised vector differs from the previous cycle. The vector is copied to the *_q registers once it has been identical for STABLE_CYCLES cycles. Input-to-_q latency is 2+STABLE_CYCLES cycles. Glitches shorter than STABLE_CYCLES are never accepted.
- Legal car codes: 1000, 0100, 0001, 1010. All others are illegal. Proceed(k) = car_k_q[0] | car_k_q[1].
- Legal walk codes: 10, 01, 00 (blink-off phase). 11 is illegal.
- Conflicts: car/car = proceed(0) & proceed(1). Walk/car = walk_k_q[0] & proceed(1-k), for either k.
- Checks are evaluated only in RUN, on the accepted (_q) values. Code priority: the lowest nonzero code wins on simultaneous violations.
- State machine:
  - IDLE -> WAIT_START when rx_rstn_q=1.
  - WAIT_START -> RUN when rx_start_q=1. WAIT_START -> IDLE when rx_rstn_q=0.
  - RUN -> FAULT on any check. RUN -> IDLE when rx_rstn_q=0. RUN -> WAIT_START when rx_start_q=0 and rx_rstn_q=1.
  - FAULT is sticky: it ignores rx_rstn_q and rx_start_q. FAULT -> IDLE on fault_clr.
  - fault_clr in any other state is ignored.
  - fault_code is latched on entry to FAULT and held until fault_clr. It reads 0 outside FAULT.
- Phase timing (RUN only):
  - The run counter increments every cycle and saturates at 2^LEN_W-1.
  - An accepted change of any lamp bit produces one change_strobe cycle. In that same cycle, phase_len <= counter+1 (saturated) and the counter restarts at 0.
  - The first change after entering RUN also strobes; its phase_len measures from RUN entry.
  - The counter clears on RUN entry.
- Stuck timer: clears on RUN entry and on each accepted lamp change. On reaching TIMEOUT_CYCLES it raises fault 5.
- A lamp change accepted in the same cycle as a violation: FAULT wins and change_strobe still pulses.
- phase_len holds its value outside RUN. It clears only on rstn.
- change_strobe is never asserted outside RUN.

Test Plan:
- Use STABLE_CYCLES=4, TIMEOUT_CYCLES=1000 for all scenarios.
- Bring-up: raise rx_rstn, then rx_start, all lamps legal. Expect link_up 7 cycles after rx_rstn and running 7 cycles after rx_start; fault=0.
- Glitch filter: in RUN, pulse rx_car_0 from 1000 to 0001 for 3 cycles, then back. Expect no change_strobe and car_0_q stays 1000. Repeat with a 5-cycle pulse: exactly one strobe on entry, then another on return.
- Phase length: in RUN, hold a pattern 200 cycles, then change it. Expect change_strobe with phase_len=200.
- Conflict: drive car_0=0001 and car_1=1010 → FAULT, fault_code=3. Then drop rx_rstn: expect FAULT held. Pulse fault_clr: expect IDLE, fault=0, fault_code=0.
- Priority: drive car_0=1111 together with walk_1=11 → fault_code=1.
- Stuck: in RUN, hold all lamps constant → fault_code=5 exactly 1000 cycles after the last accepted change.
- Async reset: assert rstn mid-RUN → all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pmod_traffic_monitor.sv
// Monitor for a remote intersection controller's PMOD lamp bus: synchronise, debounce,
// track the remote link/run state, flag illegal or conflicting lamps, time phases, detect a stuck controller.
module pmod_traffic_monitor #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000,
    parameter int unsigned LEN_W          = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx_rstn,
    input  logic             rx_start,
    input  logic [3:0]       rx_car_0,
    input  logic [1:0]       rx_walk_0,
    input  logic [3:0]       rx_car_1,
    input  logic [1:0]       rx_walk_1,
    input  logic             fault_clr,
    output logic [3:0]       car_0_q,
    output logic [3:0]       car_1_q,
    output logic [1:0]       walk_0_q,
    output logic [1:0]       walk_1_q,
    output logic             link_up,
    output logic             running,
    output logic             change_strobe,
    output logic [LEN_W-1:0] phase_len,
    output logic             fault,
    output logic [2:0]       fault_code
);

    localparam int unsigned VEC_W  = 14;
    localparam int unsigned LAMP_W = 12;
    localparam int unsigned DB_W   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES - 1) : 1;
    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(STABLE_CYCLES - 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_RUN, S_FAULT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [VEC_W-1:0]   r_sync1, r_sync2, r_last, r_q;
    logic [DB_W-1:0]    r_db_cnt;
    logic [LEN_W-1:0]   r_run_cnt, r_phase_len;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_strobe, r_link_up, r_running, r_fault;
    logic [2:0]         r_fault_code;

    logic [VEC_W-1:0]   w_vec;
    logic               w_accept, w_lamp_chg, w_stuck, w_strobe, w_run_entry;
    logic               w_rx_rstn_q, w_rx_start_q, w_proc0, w_proc1;
    logic [3:0]         w_car0, w_car1;
    logic [1:0]         w_walk0, w_walk1;
    logic [2:0]         w_code;
    logic [LEN_W-1:0]   w_run_inc;

    function automatic logic car_ok(input logic [3:0] c);
        return (c == 4'b1000) || (c == 4'b0100) || (c == 4'b0001) || (c == 4'b1010);
    endfunction

    assign w_vec = {rx_rstn, rx_start, rx_car_1, rx_walk_1, rx_car_0, rx_walk_0};

    // r_db_cnt counts consecutive equal samples; accept once the window reaches STABLE_CYCLES
    assign w_accept   = (r_sync2 == r_last) && (r_db_cnt == DB_LAST);
    assign w_lamp_chg = w_accept && (r_sync2[LAMP_W-1:0] != r_q[LAMP_W-1:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_last   <= '0;
            r_db_cnt <= '0;
            r_q      <= '0;
        end else begin
            r_sync1 <= w_vec;
            r_sync2 <= r_sync1;
            r_last  <= r_sync2;
            if (r_sync2 != r_last) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt != DB_LAST) begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
            if (w_accept) begin
                r_q <= r_sync2;
            end
        end
    end

    assign w_rx_rstn_q  = r_q[13];
    assign w_rx_start_q = r_q[12];
    assign w_car1       = r_q[11:8];
    assign w_walk1      = r_q[7:6];
    assign w_car0       = r_q[5:2];
    assign w_walk0      = r_q[1:0];
    assign w_proc0      = w_car0[0] | w_car0[1];
    assign w_proc1      = w_car1[0] | w_car1[1];
    assign w_stuck      = (r_tmo == TMO_LAST) && !w_lamp_chg;

    // Later assignments override earlier ones, so the lowest code wins
    always_comb begin
        w_code = 3'd0;
        if (w_stuck) w_code = 3'd5;
        if ((w_walk0[0] && w_proc1) || (w_walk1[0] && w_proc0)) w_code = 3'd4;
        if (w_proc0 && w_proc1) w_code = 3'd3;
        if ((w_walk0 == 2'b11) || (w_walk1 == 2'b11)) w_code = 3'd2;
        if (!car_ok(w_car0) || !car_ok(w_car1)) w_code = 3'd1;
    end

    always_comb begin
        w_next   = r_state;
        w_strobe = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rx_rstn_q) w_next = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!w_rx_rstn_q)      w_next = S_IDLE;
                else if (w_rx_start_q) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_code != 3'd0)     w_next = S_FAULT;
                else if (!w_rx_rstn_q)  w_next = S_IDLE;
                else if (!w_rx_start_q) w_next = S_WAIT_START;
            end
            S_FAULT: begin
                if (fault_clr) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        w_strobe = (r_state == S_RUN) && w_lamp_chg && ((w_next == S_RUN) || (w_next == S_FAULT));
    end

    assign w_run_entry = (w_next == S_RUN) && (r_state != S_RUN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_link_up    <= 1'b0;
            r_running    <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= 3'd0;
        end else begin
            r_state      <= w_next;
            r_link_up    <= (w_next != S_IDLE);
            r_running    <= (w_next == S_RUN);
            r_fault      <= (w_next == S_FAULT);
            r_fault_code <= (w_next == S_FAULT) ? ((r_state == S_FAULT) ? r_fault_code : w_code) : 3'd0;
        end
    end

    assign w_run_inc = (r_run_cnt == {LEN_W{1'b1}}) ? r_run_cnt : r_run_cnt + LEN_W'(1);

    // Phase counter and stuck timer both restart on RUN entry and on every accepted lamp change
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run_cnt   <= '0;
            r_tmo       <= '0;
            r_phase_len <= '0;
            r_strobe    <= 1'b0;
        end else begin
            r_strobe <= w_strobe;
            if (w_run_entry) begin
                r_run_cnt <= '0;
                r_tmo     <= '0;
            end else if (r_state == S_RUN) begin
                if (w_lamp_chg) begin
                    r_run_cnt <= '0;
                    r_tmo     <= '0;
                end else begin
                    r_run_cnt <= w_run_inc;
                    r_tmo     <= r_tmo + TMO_W'(1);
                end
            end
            if (w_strobe) begin
                r_phase_len <= w_run_inc;
            end
        end
    end

    assign car_0_q       = r_q[5:2];
    assign car_1_q       = r_q[11:8];
    assign walk_0_q      = r_q[1:0];
    assign walk_1_q      = r_q[7:6];
    assign link_up       = r_link_up;
    assign running       = r_running;
    assign change_strobe = r_strobe;
    assign phase_len     = r_phase_len;
    assign fault         = r_fault;
    assign fault_code    = r_fault_code;

endmodule
